// File: rtl/scoreboard_pkg.sv
// Shared definitions for the occupancy scoreboard: statistics width and limits,
// the per-channel check result encoding and a saturating statistics adder.
package scoreboard_pkg;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MIN = '0;
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  typedef enum logic [1:0] {
    CHK_NONE = 2'd0,
    CHK_PASS = 2'd1,
    CHK_FAIL = 2'd2
  } chk_result_e;

  // Adds a per-cycle check tally to a statistic, clamping at STAT_MAX.
  function automatic logic [STAT_W-1:0] stat_sat_add(input logic [STAT_W-1:0] base,
                                                     input logic [STAT_W-1:0] incr);
    logic [STAT_W:0] sum;
    sum = {1'b0, base} + {1'b0, incr};
    return sum[STAT_W] ? STAT_MAX : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/sb_channel.sv
// One scoreboard channel: rising-edge detect on the expected strobes, the
// reference occupancy counter, and the single per-cycle check against the DUT.
module sb_channel
  import scoreboard_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_exp,
  input  logic             dec_exp,
  input  logic             inc_act,
  input  logic             dec_act,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] local_count,
  output chk_result_e      result
);

  localparam logic [WIDTH-1:0] CNT_MIN = '0;
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             inc_prev_q, inc_prev_d;
  logic             dec_prev_q, dec_prev_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             inc_rise;
  logic             dec_rise;
  logic             check_ok;

  // Both rises share one check; increment wins the counter update when both fire.
  always_comb begin
    inc_rise   = inc_exp & ~inc_prev_q;
    dec_rise   = dec_exp & ~dec_prev_q;
    inc_prev_d = inc_exp;
    dec_prev_d = dec_exp;
    check_ok   = (count == count_q) && (inc_act == inc_exp) && (dec_act == dec_exp);

    result = CHK_NONE;
    if (inc_rise || dec_rise) begin
      result = check_ok ? CHK_PASS : CHK_FAIL;
    end

    count_d = count_q;
    if (inc_rise) begin
      if (count_q == CNT_MAX) begin
        count_d = (SATURATE != 0) ? CNT_MAX : CNT_MIN;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else if (dec_rise) begin
      if (count_q == CNT_MIN) begin
        count_d = (SATURATE != 0) ? CNT_MIN : CNT_MAX;
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_prev_q <= 1'b0;
      dec_prev_q <= 1'b0;
      count_q    <= CNT_MIN;
    end else begin
      inc_prev_q <= inc_prev_d;
      dec_prev_q <= dec_prev_d;
      count_q    <= count_d;
    end
  end

  assign local_count = count_q;

endmodule

// File: rtl/occupancy_scoreboard.sv
// Multi-channel occupancy scoreboard: mirrors a DUT's up/down counters from the
// expected strobes and accumulates pass/fail statistics across all channels.
module occupancy_scoreboard
  import scoreboard_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 2,
  parameter  int SATURATE = 1,
  localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr_stats,
  input  logic [CHANNELS-1:0]       inc_exp,
  input  logic [CHANNELS-1:0]       dec_exp,
  input  logic [CHANNELS-1:0]       inc_act,
  input  logic [CHANNELS-1:0]       dec_act,
  input  logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS*WIDTH-1:0] local_count,
  output logic [STAT_W-1:0]         pass_count,
  output logic [STAT_W-1:0]         fail_count,
  output logic                      mismatch,
  output logic [CHAN_W-1:0]         mismatch_chan,
  output logic                      sticky_fail
);

  chk_result_e results [CHANNELS];

  logic [STAT_W-1:0] pass_count_q, pass_count_d;
  logic [STAT_W-1:0] fail_count_q, fail_count_d;
  logic              mismatch_q, mismatch_d;
  logic [CHAN_W-1:0] mismatch_chan_q, mismatch_chan_d;
  logic              sticky_fail_q, sticky_fail_d;

  logic [STAT_W-1:0] pass_num;
  logic [STAT_W-1:0] fail_num;
  logic [CHAN_W-1:0] fail_chan;
  logic              any_fail;
  logic [STAT_W-1:0] pass_base;
  logic [STAT_W-1:0] fail_base;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    sb_channel #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .inc_exp     (inc_exp[c]),
      .dec_exp     (dec_exp[c]),
      .inc_act     (inc_act[c]),
      .dec_act     (dec_act[c]),
      .count       (count[c*WIDTH +: WIDTH]),
      .local_count (local_count[c*WIDTH +: WIDTH]),
      .result      (results[c])
    );
  end

  // Scanning from the top channel down leaves the lowest failing index in fail_chan.
  always_comb begin
    pass_num  = '0;
    fail_num  = '0;
    fail_chan = '0;
    any_fail  = 1'b0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (results[c] == CHK_PASS) begin
        pass_num = pass_num + STAT_W'(1);
      end
      if (results[c] == CHK_FAIL) begin
        fail_num  = fail_num + STAT_W'(1);
        fail_chan = CHAN_W'(c);
        any_fail  = 1'b1;
      end
    end
  end

  // A clear restarts the statistics from zero, but this cycle's checks still land on top.
  always_comb begin
    pass_base       = clr_stats ? STAT_MIN : pass_count_q;
    fail_base       = clr_stats ? STAT_MIN : fail_count_q;
    pass_count_d    = stat_sat_add(pass_base, pass_num);
    fail_count_d    = stat_sat_add(fail_base, fail_num);
    mismatch_d      = any_fail;
    mismatch_chan_d = any_fail ? fail_chan : mismatch_chan_q;
    sticky_fail_d   = any_fail | (sticky_fail_q & ~clr_stats);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_count_q    <= STAT_MIN;
      fail_count_q    <= STAT_MIN;
      mismatch_q      <= 1'b0;
      mismatch_chan_q <= '0;
      sticky_fail_q   <= 1'b0;
    end else begin
      pass_count_q    <= pass_count_d;
      fail_count_q    <= fail_count_d;
      mismatch_q      <= mismatch_d;
      mismatch_chan_q <= mismatch_chan_d;
      sticky_fail_q   <= sticky_fail_d;
    end
  end

  assign pass_count    = pass_count_q;
  assign fail_count    = fail_count_q;
  assign mismatch      = mismatch_q;
  assign mismatch_chan = mismatch_chan_q;
  assign sticky_fail   = sticky_fail_q;

endmodule

// File: tb/tb_occupancy_scoreboard.sv
// Bench for occupancy_scoreboard: a saturating and a wrapping instance share the
// strobes and are compared every cycle against an integer reference model.
module tb_occupancy_scoreboard;

  localparam int W    = 4;
  localparam int CH   = 2;
  localparam int NI   = 2;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic reset;
  logic clr_stats;
  logic [CH-1:0]   inc_exp, dec_exp, inc_act, dec_act;
  logic [CH*W-1:0] count_in  [NI];
  logic [CH*W-1:0] lc_out    [NI];
  logic [15:0]     pass_out  [NI];
  logic [15:0]     fail_out  [NI];
  logic            mis_out   [NI];
  logic [0:0]      chan_out  [NI];
  logic            stick_out [NI];

  int m_cnt [NI][CH];
  int m_pass [NI];
  int m_fail [NI];
  int m_chan [NI];
  bit m_mis [NI];
  bit m_sticky [NI];
  bit m_pinc [CH];
  bit m_pdec [CH];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  occupancy_scoreboard #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1)) u_dut_sat (
    .clk           (clk),
    .reset         (reset),
    .clr_stats     (clr_stats),
    .inc_exp       (inc_exp),
    .dec_exp       (dec_exp),
    .inc_act       (inc_act),
    .dec_act       (dec_act),
    .count         (count_in[0]),
    .local_count   (lc_out[0]),
    .pass_count    (pass_out[0]),
    .fail_count    (fail_out[0]),
    .mismatch      (mis_out[0]),
    .mismatch_chan (chan_out[0]),
    .sticky_fail   (stick_out[0])
  );

  occupancy_scoreboard #(.WIDTH(W), .CHANNELS(CH), .SATURATE(0)) u_dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .clr_stats     (clr_stats),
    .inc_exp       (inc_exp),
    .dec_exp       (dec_exp),
    .inc_act       (inc_act),
    .dec_act       (dec_act),
    .count         (count_in[1]),
    .local_count   (lc_out[1]),
    .pass_count    (pass_out[1]),
    .fail_count    (fail_out[1]),
    .mismatch      (mis_out[1]),
    .mismatch_chan (chan_out[1]),
    .sticky_fail   (stick_out[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < CH; c++) m_cnt[i][c] = 0;
      m_pass[i] = 0; m_fail[i] = 0; m_chan[i] = 0; m_mis[i] = 0; m_sticky[i] = 0;
    end
    for (int c = 0; c < CH; c++) begin
      m_pinc[c] = 0; m_pdec[c] = 0;
    end
  endtask

  // Reference behaviour for one clock edge; instance 0 saturates, instance 1 wraps mod 16.
  task automatic model_step();
    int passes, fails, first, nxt;
    bit ir, dr, ok;
    for (int i = 0; i < NI; i++) begin
      passes = 0; fails = 0; first = -1;
      for (int c = 0; c < CH; c++) begin
        ir = inc_exp[c] && !m_pinc[c];
        dr = dec_exp[c] && !m_pdec[c];
        if (ir || dr) begin
          ok = (int'(count_in[i][c*W +: W]) == m_cnt[i][c]) &&
               (inc_act[c] == inc_exp[c]) && (dec_act[c] == dec_exp[c]);
          if (ok) passes++;
          else begin
            fails++;
            if (first < 0) first = c;
          end
        end
        if (ir) begin
          nxt = m_cnt[i][c] + 1;
          m_cnt[i][c] = (i == 0) ? ((nxt > CMAX) ? CMAX : nxt) : (nxt % (CMAX + 1));
        end else if (dr) begin
          nxt = m_cnt[i][c] - 1;
          m_cnt[i][c] = (i == 0) ? ((nxt < 0) ? 0 : nxt) : ((nxt + CMAX + 1) % (CMAX + 1));
        end
      end
      m_pass[i] = (clr_stats ? 0 : m_pass[i]) + passes;
      if (m_pass[i] > 65535) m_pass[i] = 65535;
      m_fail[i] = (clr_stats ? 0 : m_fail[i]) + fails;
      if (m_fail[i] > 65535) m_fail[i] = 65535;
      m_mis[i] = (fails > 0);
      if (fails > 0) m_chan[i] = first;
      m_sticky[i] = (fails > 0) || (m_sticky[i] && !clr_stats);
    end
    for (int c = 0; c < CH; c++) begin
      m_pinc[c] = inc_exp[c];
      m_pdec[c] = dec_exp[c];
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < CH; c++)
        checkOutput($sformatf("i%0d.local_count[%0d]", i, c), 32'(lc_out[i][c*W +: W]), m_cnt[i][c]);
      checkOutput($sformatf("i%0d.pass_count", i), 32'(pass_out[i]), m_pass[i]);
      checkOutput($sformatf("i%0d.fail_count", i), 32'(fail_out[i]), m_fail[i]);
      checkOutput($sformatf("i%0d.mismatch", i), 32'(mis_out[i]), 32'(m_mis[i]));
      checkOutput($sformatf("i%0d.mismatch_chan", i), 32'(chan_out[i]), m_chan[i]);
      checkOutput($sformatf("i%0d.sticky_fail", i), 32'(stick_out[i]), 32'(m_sticky[i]));
    end
  endtask

  // Drives one cycle of strobes; the DUT count mirrors the model unless cnt_err flips its LSB.
  task automatic applyStimulus(input logic [CH-1:0] inc, input logic [CH-1:0] dec,
                               input logic [CH-1:0] inc_err, input logic [CH-1:0] dec_err,
                               input logic [CH-1:0] cnt_err, input logic clr);
    inc_exp   = inc;
    dec_exp   = dec;
    inc_act   = inc ^ inc_err;
    dec_act   = dec ^ dec_err;
    clr_stats = clr;
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < CH; c++)
        count_in[i][c*W +: W] = W'(m_cnt[i][c]) ^ (cnt_err[c] ? 4'd1 : 4'd0);
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse(input logic [CH-1:0] inc, input logic [CH-1:0] dec, input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(inc, dec, '0, '0, '0, 1'b0);
      applyStimulus('0, '0, '0, '0, '0, 1'b0);
    end
  endtask

  task automatic do_reset();
    inc_exp = '0; dec_exp = '0; inc_act = '0; dec_act = '0; clr_stats = 1'b0;
    #2 reset = 1'b1;
    #1 model_reset();
    compare_all();
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin
    logic [CH-1:0] ri, rd, e1, e2, e3;
    reset = 1'b1; clr_stats = 1'b0;
    inc_exp = '0; dec_exp = '0; inc_act = '0; dec_act = '0;
    count_in[0] = '0; count_in[1] = '0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk) reset = 1'b0;

    pulse(2'b01, 2'b00, 5);
    checkOutput("five_inc.local_count0", 32'(lc_out[0][3:0]), 5);
    checkOutput("five_inc.pass_count", 32'(pass_out[0]), 5);
    checkOutput("five_inc.fail_count", 32'(fail_out[0]), 0);
    checkOutput("five_inc.sticky_fail", 32'(stick_out[0]), 0);

    do_reset();
    pulse(2'b10, 2'b00, 17);
    checkOutput("sat17.local_count1", 32'(lc_out[0][7:4]), 15);
    checkOutput("wrap17.local_count1", 32'(lc_out[1][7:4]), 1);
    pulse(2'b00, 2'b10, 16);
    checkOutput("sat_dec16.local_count1", 32'(lc_out[0][7:4]), 0);
    checkOutput("wrap_dec16.local_count1", 32'(lc_out[1][7:4]), 1);

    do_reset();
    pulse(2'b01, 2'b00, 16);
    checkOutput("wrap16.local_count0", 32'(lc_out[1][3:0]), 0);
    checkOutput("sat16.local_count0", 32'(lc_out[0][3:0]), 15);

    applyStimulus('0, '0, '0, '0, '0, 1'b1);
    applyStimulus(2'b10, '0, '0, '0, 2'b10, 1'b0);
    checkOutput("offby1.mismatch", 32'(mis_out[0]), 1);
    checkOutput("offby1.mismatch_chan", 32'(chan_out[0]), 1);
    checkOutput("offby1.fail_count", 32'(fail_out[0]), 1);
    checkOutput("offby1.sticky_fail", 32'(stick_out[0]), 1);
    applyStimulus('0, '0, '0, '0, '0, 1'b0);
    checkOutput("offby1.mismatch_drop", 32'(mis_out[0]), 0);
    checkOutput("offby1.chan_hold", 32'(chan_out[0]), 1);

    do_reset();
    pulse(2'b01, 2'b00, 3);
    applyStimulus('0, '0, '0, '0, '0, 1'b1);
    applyStimulus(2'b01, 2'b01, '0, '0, '0, 1'b0);
    checkOutput("both_rise.local_count0", 32'(lc_out[0][3:0]), 4);
    checkOutput("both_rise.pass_count", 32'(pass_out[0]), 1);

    do_reset();
    pulse(2'b01, 2'b00, 7);
    checkOutput("pre_reset.local_count0", 32'(lc_out[0][3:0]), 7);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset.local_count", 32'(lc_out[0]), 0);
    checkOutput("async_reset.pass_count", 32'(pass_out[0]), 0);
    checkOutput("async_reset.sticky_fail", 32'(stick_out[0]), 0);
    model_reset();
    applyStimulus(2'b01, '0, '0, '0, '0, 1'b0);
    #2 reset = 1'b0;
    applyStimulus(2'b01, '0, '0, '0, '0, 1'b0);
    checkOutput("release_high.local_count0", 32'(lc_out[0][3:0]), 1);
    checkOutput("release_high.pass_count", 32'(pass_out[0]), 1);
    applyStimulus('0, '0, '0, '0, '0, 1'b1);
    checkOutput("clr.local_count0", 32'(lc_out[0][3:0]), 1);
    checkOutput("clr.pass_count", 32'(pass_out[0]), 0);

    for (int k = 0; k < 400; k++) begin
      ri = 2'($urandom_range(0, 3));
      rd = 2'($urandom_range(0, 3));
      e1 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      e2 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      e3 = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus(ri, rd, e1, e2, e3, ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
